// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Also provides the lapido_defs macros: `PC_WIDTH, `NOP_INSTRUCTION, `FC_IDLE/`FC_RUN/`FC_FLUSH.
`ifndef LAPIDO_DEFS_V
`define LAPIDO_DEFS_V
`define PC_WIDTH        8
`define NOP_INSTRUCTION 32'h0000_0013
`define FC_IDLE         2'd0
`define FC_RUN          2'd1
`define FC_FLUSH        2'd2
`endif

package fetch_controller_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = `FC_IDLE,
    ST_RUN   = `FC_RUN,
    ST_FLUSH = `FC_FLUSH
  } fc_state_t;

endpackage

// File: rtl/fetch_controller_slot_counter.sv
// Slot counter shared by RUN and FLUSH: 4-bit modulo counter that wraps
// to zero on the terminal value supplied by the caller.
module slot_counter
  import fetch_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == term);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, paces sequential fetch and flushes after redirects.
// Optional hazard stall input is enabled with `FETCH_CTRL_STALL_EN.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int CPI          = 5,
  parameter int FLUSH_CYCLES = 3,
  parameter int PC_W         = `PC_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_addr,
  input  logic            is_jump,
  input  logic [PC_W-1:0] jump_addr,
`ifdef FETCH_CTRL_STALL_EN
  input  logic            stall,
`endif
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            write_pc,
  output logic            if_enable,
  output logic            flushing
);

  fc_state_t        state;
  logic [PC_W-1:0]  target;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             tc;
  logic             redirect;
  logic             stall_run;
  logic             cnt_en;
  logic             cnt_clr;

`ifdef FETCH_CTRL_STALL_EN
  assign stall_run = stall && (state == ST_RUN);
`else
  assign stall_run = 1'b0;
`endif

  // Redirects are ignored in IDLE and always win over a stall.
  assign redirect = (branch_taken || is_jump) && (state != ST_IDLE);
  assign term     = (state == ST_FLUSH) ? CNT_W'(FLUSH_CYCLES - 1) : CNT_W'(CPI - 1);
  assign cnt_clr  = (state == ST_IDLE) || redirect;
  assign cnt_en   = (state == ST_FLUSH) || ((state == ST_RUN) && !stall_run);

  always_comb begin
    write_pc = 1'b0;
    pc_next  = pc + PC_W'(1);
    if (rst) begin
      pc_next = PC_W'(1);
    end else begin
      case (state)
        ST_RUN:   write_pc = tc && !redirect && !stall_run;
        ST_FLUSH: begin
          write_pc = tc && !redirect;
          pc_next  = target;
        end
        default:  write_pc = 1'b0;
      endcase
    end
  end

  slot_counter u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (term),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      target    <= '0;
      if_enable <= 1'b0;
      flushing  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_RUN;
          if_enable <= 1'b1;
          flushing  <= 1'b0;
        end
        ST_RUN, ST_FLUSH: begin
          if (redirect) begin
            // Branch comes from the older instruction, so it beats a jump.
            target    <= branch_taken ? branch_addr : jump_addr;
            state     <= ST_FLUSH;
            if_enable <= 1'b0;
            flushing  <= 1'b1;
          end else if (write_pc) begin
            pc        <= pc_next;
            state     <= ST_RUN;
            if_enable <= 1'b1;
            flushing  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          if_enable <= 1'b0;
          flushing  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller (CPI=5, FLUSH_CYCLES=3, PC_W=8) with a
// queue of expected PC writes checked whenever write_pc fires.
module tb_fetch_controller;

  localparam int CPI = 5;
  localparam int FC  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       branch_taken, is_jump;
  logic [7:0] branch_addr, jump_addr;
  logic       stall;
  logic [7:0] pc, pc_next;
  logic       write_pc, if_enable, flushing;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_controller #(.CPI(CPI), .FLUSH_CYCLES(FC), .PC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .is_jump      (is_jump),
    .jump_addr    (jump_addr),
`ifdef FETCH_CTRL_STALL_EN
    .stall        (stall),
`endif
    .pc           (pc),
    .pc_next      (pc_next),
    .write_pc     (write_pc),
    .if_enable    (if_enable),
    .flushing     (flushing)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; every PC write is matched against the scoreboard.
  task automatic cyc();
    #1;
    if (!rst && write_pc) begin
      if (exp_q.size() == 0) chk("unexpected_write", {24'h0, pc_next}, 32'h1ff);
      else                   chk("pc_write", {24'h0, pc_next}, {24'h0, exp_q.pop_front()});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Apply a one-cycle redirect and walk the flush slots to the target fetch.
  task automatic do_redirect(input logic bt, input logic [7:0] ba, input logic ij,
                             input logic [7:0] ja, input logic [7:0] exp);
    branch_taken = bt; branch_addr = ba;
    is_jump = ij;      jump_addr = ja;
    #1;
    chk("redir_wr", write_pc, 0);
    exp_q.push_back(exp);
    cyc();
    branch_taken = 1'b0; is_jump = 1'b0;
    for (int k = 0; k < FC; k++) begin
      #1;
      chk("flush_ife", if_enable, 0);
      chk("flush_flag", flushing, 1);
      chk("flush_wr", write_pc, (k == FC - 1) ? 1 : 0);
      cyc();
    end
    chk("target_pc", pc, exp);
    chk("target_ife", if_enable, 1);
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; is_jump = 1'b0;
    branch_addr = '0; jump_addr = '0; stall = 1'b0;
    @(negedge clk);
    run(2);
    chk("rst_pc", pc, 0);
    chk("rst_ife", if_enable, 0);
    chk("rst_flush", flushing, 0);
    chk("rst_wr", write_pc, 0);
    chk("rst_pcn", pc_next, 1);

    rst = 1'b0;
    #1;
    chk("idle_ife", if_enable, 0);
    cyc();
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("seq_pc", pc, i / CPI);
      chk("seq_wr", write_pc, (i % CPI == CPI - 1) ? 1 : 0);
      chk("seq_ife", if_enable, 1);
      cyc();
    end
    chk("seq_pc40", pc, 8);

    // Branch at cnt=2, then the target must hold for a full CPI.
    run(2);
    do_redirect(1'b1, 8'd6, 1'b0, 8'd0, 8'd6);
    exp_q.push_back(8'd7);
    for (int k = 0; k < CPI; k++) begin
      #1;
      chk("post_br_wr", write_pc, (k == CPI - 1) ? 1 : 0);
      cyc();
    end

    run(1);
    do_redirect(1'b1, 8'd2, 1'b1, 8'd5, 8'd2);

    // Jump to 7, branch to 4 one cycle later: 7 must never be written.
    is_jump = 1'b1; jump_addr = 8'd7;
    cyc();
    is_jump = 1'b0;
    do_redirect(1'b1, 8'd4, 1'b0, 8'd0, 8'd4);

    // Redirect at cnt=4 with pc=0x10: no 0x11 write.
    do_redirect(1'b0, 8'd0, 1'b1, 8'h10, 8'h10);
    run(CPI - 1);
    chk("cnt4_pc", pc, 8'h10);
    do_redirect(1'b0, 8'd0, 1'b1, 8'h20, 8'h20);

    // Wrap 0xFF -> 0x00.
    do_redirect(1'b1, 8'hff, 1'b0, 8'd0, 8'hff);
    exp_q.push_back(8'h00);
    run(CPI);
    chk("wrap_pc", pc, 0);

`ifdef FETCH_CTRL_STALL_EN
    run(1);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_wr", write_pc, 0);
      chk("stall_ife", if_enable, 1);
      chk("stall_pc", pc, 0);
      cyc();
    end
    stall = 1'b0;
    exp_q.push_back(8'd1);
    for (int k = 0; k < CPI - 1; k++) begin
      #1;
      chk("unstall_wr", write_pc, (k == CPI - 2) ? 1 : 0);
      cyc();
    end
    stall = 1'b1;
    do_redirect(1'b0, 8'd0, 1'b1, 8'd9, 8'd9);
    stall = 1'b0;
`endif

    // Reset mid-flush discards the pending target.
    is_jump = 1'b1; jump_addr = 8'h33;
    cyc();
    is_jump = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_flush", flushing, 0);
    chk("mid_rst_ife", if_enable, 0);
    chk("mid_rst_wr", write_pc, 0);
    rst = 1'b0;
    cyc();
    exp_q.push_back(8'd1);
    run(CPI);
    chk("after_rst_pc", pc, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the instruction-fetch stage. Owns the program counter. Paces fetch at a fixed number of cycles per instruction and decides each cycle whether the fetch stage presents the fetched word or a NOP (`if_enable`). Accepts redirect requests from the branch unit and the jump decoder, then flushes for a fixed number of slots before fetching the target. It sits between the decode/execute redirect sources and the IF stage's PC register, memory and NOP mux.

## Interface
- `CPI`, default 5: cycles each sequential instruction is held; legal range 2..16.
- `FLUSH_CYCLES`, default 3: NOP slots after a redirect; legal range 1..16.
- `PC_W`, default `` `PC_WIDTH ``: program-counter width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `branch_taken`  in  1  branch resolved taken this cycle.
- `branch_addr`  in  PC_W  branch target, already computed.
- `is_jump`  in  1  jump decoded this cycle.
- `jump_addr`  in  PC_W  jump target.
- `stall`  in  1  hazard stall; present only with `FETCH_CTRL_STALL_EN`.
- `pc`  out  PC_W  current PC, registered.
- `pc_next`  out  PC_W  value loaded into `pc` when `write_pc` is high.
- `write_pc`  out  1  PC update strobe, combinational.
- `if_enable`  out  1  1 = IF presents the fetched word; 0 = IF presents `` `NOP_INSTRUCTION ``.
- `flushing`  out  1  state is FLUSH.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: sequential fetch.
  - FLUSH: NOP slots after a redirect.
- One slot counter `cnt`, 4 bits, shared by RUN and FLUSH.
- Held in reset: state IDLE, `pc`=0, `cnt`=0, redirect target register=0, `if_enable`=0, `write_pc`=0, `flushing`=0, `pc_next`=1.
- IDLE: lasts exactly one cycle after `rst` deasserts, then goes to RUN with `cnt`=0. Redirects seen in IDLE are ignored.
- RUN:
  - `if_enable`=1.
  - `cnt` increments each cycle.
  - When `cnt`==CPI-1: `write_pc`=1, `pc_next`=`pc`+1 (wraps modulo 2^PC_W), `cnt` returns to 0.
- Redirect (`branch_taken | is_jump`) seen in RUN or FLUSH:
  - Latch the target. Branch has priority over jump when both are asserted, because the branch is from the older instruction.
  - Next state FLUSH, `cnt`=0.
  - `write_pc`=0 in the redirect cycle, even when `cnt`==CPI-1.
- FLUSH:
  - `if_enable`=0, `flushing`=1, `pc_next`=latched target.
  - When `cnt`==FLUSH_CYCLES-1 and no new redirect: `write_pc`=1, next state RUN, `cnt`=0.
  - A new redirect during FLUSH replaces the target and restarts `cnt` at 0. The flush is extended, never shortened.
- Reset asserted mid-RUN or mid-FLUSH: back to IDLE on the next edge. Any pending target is discarded.

## Timing
- Redirect inputs are sampled at the rising edge. The first NOP slot is the cycle after the redirect cycle.
- Redirect to target fetch latency: FLUSH_CYCLES+1 cycles. The target appears on `pc` with `if_enable`=1 in cycle FLUSH_CYCLES+1 after the redirect cycle.
- Sequential throughput: one PC increment every CPI cycles.
- `write_pc` and `pc_next` are combinational from state, `cnt`, the redirect inputs and `stall`. `if_enable` and `flushing` depend on state only.

## Configuration
- `FETCH_CTRL_STALL_EN` defined:
  - The `stall` port exists.
  - `stall`=1 in RUN freezes `cnt`, `pc` and state, and forces `write_pc`=0. `if_enable` stays 1.
  - A redirect overrides `stall` and enters FLUSH.
  - `stall` is ignored in FLUSH and IDLE.
- Not defined: no `stall` port; behaviour is identical to `stall` tied to 0.

## Structure
- In `lapido_defs.v`:
  - `` `PC_WIDTH ``, `` `NOP_INSTRUCTION ``.
  - State encodings `` `FC_IDLE ``, `` `FC_RUN ``, `` `FC_FLUSH `` (2 bits).
- One sub-module `slot_counter`: 4-bit modulo counter with synchronous clear, enable and terminal-count compare input. It is instantiated once and its terminal value is muxed by state (CPI-1 or FLUSH_CYCLES-1).

## Test plan
All scenarios use CPI=5, FLUSH_CYCLES=3, PC_W=8.
- Reset, sequential run: `rst`=1 for 2 cycles, then 0 → 1 IDLE cycle with `if_enable`=0. `pc` holds each value for 5 cycles with `write_pc` on the 5th; `pc`=8 after 40 RUN cycles.
- Branch: at `pc`=3, `cnt`=2, pulse `branch_taken` with `branch_addr`=6 → 3 cycles with `if_enable`=0 and `write_pc` in the 3rd. Then `pc`=6, `if_enable`=1, `cnt`=0.
- Simultaneous redirect: `branch_taken`=1 `branch_addr`=2 and `is_jump`=1 `jump_addr`=5 in the same cycle → `pc`=2 after the flush.
- Redirect during flush: jump to 7, then one cycle later branch to 4 → 3 NOP slots counted from the branch, `pc` never equals 7, final `pc`=4.
- Redirect at `cnt`=4 with `pc`=0x10 → no `pc`=0x11 write; `pc` goes straight to the target after the flush.
- Wrap and stall (with `FETCH_CTRL_STALL_EN`): `pc`=0xFF increments to 0x00. `stall`=1 for 4 cycles at `cnt`=1 delays the next `write_pc` by exactly 4 cycles. `stall` plus a jump to 9 still yields `pc`=9.
